// File: rtl/data_sync_arb.sv
// ----------------------------------------------------------------------------
// data_sync_arb
//
// Round-robin sequencer that time-shares a single data_sync instance between
// N_REQ requesters. One requester is granted at a time. Its word is launched
// onto the synchronizer input and held there until the synchronizer output
// has settled. The settled value is then captured and returned to that
// requester with a one-cycle response pulse.
//
// Ports:
//   clk_i        single clock
//   rst_n_i      asynchronous, active-low reset
//   req_valid_i  per-requester request
//   req_data_i   per-requester word, requester k at [k*D_WIDTH +: D_WIDTH]
//   req_ready_o  one-hot accept strobe (combinational, IDLE only)
//   rsp_valid_o  one-hot, one-cycle response pulse (registered)
//   rsp_data_o   synchronized word returned to the granted requester
//   sync_data_o  drives data_sync.data_i; holds the last launched word
//   sync_data_i  from data_sync.data_o
//   busy_o       high whenever the sequencer is not IDLE
// ----------------------------------------------------------------------------
module data_sync_arb #(
   parameter int D_WIDTH     = 8,
   parameter int N_REQ       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_EXTRA  = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   input  logic [N_REQ*D_WIDTH-1:0] req_data_i,
   output logic [N_REQ-1:0]         req_ready_o,
   output logic [N_REQ-1:0]         rsp_valid_o,
   output logic [D_WIDTH-1:0]       rsp_data_o,
   output logic [D_WIDTH-1:0]       sync_data_o,
   input  logic [D_WIDTH-1:0]       sync_data_i,
   output logic                     busy_o
);

   // Number of cycles the launched word is held in WAIT beyond the first.
   localparam int LAT   = SYNC_STAGES + HOLD_EXTRA;
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CAPTURE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] grant_q;
   logic             grant_found;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // Round-robin search: start at ptr, scan upward with wrap, first valid
   // request wins. The !grant_found guard keeps the earliest hit.
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] cand;
      idx         = 0;
      cand        = '0;
      grant_idx   = ptr;
      grant_found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx  = (int'(ptr) + i) % N_REQ;
         cand = PTR_W'(idx);
         if (!grant_found && req_valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Ready is gated by reset so no strobe is visible while rst_n_i is low,
   // even though the state register already reads IDLE then.
   assign accept = rst_n_i && (state == IDLE) && grant_found;

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. WAIT exits on the edge where the counter reads zero,
   // so a zero latency still spends exactly one cycle in WAIT.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_found) state_next = WAIT;
         WAIT:    if (cnt == '0) state_next = CAPTURE;
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Combinational outputs: busy flag and the one-hot accept strobe.
   always_comb begin
      busy_o      = (state != IDLE);
      req_ready_o = '0;
      if (accept) begin
         req_ready_o = N_REQ'(1) << grant_idx;
      end
   end

   // Datapath: launch on accept, count down in WAIT, capture and respond on
   // leaving CAPTURE. The pointer advances past the granted index only when
   // the transaction completes, so a reset mid-flight leaves it at zero.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_data_o <= '0;
         rsp_data_o  <= '0;
         rsp_valid_o <= '0;
         grant_q     <= '0;
         cnt         <= '0;
         ptr         <= '0;
      end else begin
         rsp_valid_o <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  sync_data_o <= req_data_i[grant_idx*D_WIDTH +: D_WIDTH];
                  grant_q     <= grant_idx;
                  cnt         <= CNT_W'(LAT);
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            CAPTURE: begin
               rsp_data_o  <= sync_data_i;
               rsp_valid_o <= N_REQ'(1) << grant_q;
               if (int'(grant_q) == N_REQ - 1) begin
                  ptr <= '0;
               end else begin
                  ptr <= grant_q + PTR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_sync_arb.sv
// ----------------------------------------------------------------------------
// tb_data_sync_arb
//
// Scoreboard bench for data_sync_arb. A behavioural two-stage synchronizer
// closes the loop between sync_data_o and sync_data_i. Stimulus pushes the
// expected grant order and responses into queues; monitors pop and compare
// whenever the DUT accepts or responds. A second instance with N_REQ=1
// covers the single-requester case.
// ----------------------------------------------------------------------------
module tb_data_sync_arb;

   localparam int D_WIDTH     = 8;
   localparam int N_REQ       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int HOLD_EXTRA  = 1;
   localparam int LAT         = SYNC_STAGES + HOLD_EXTRA;

   typedef struct {
      int              req;
      logic [7:0]      data;
   } rsp_t;

   typedef struct {
      int req;
      int gap;
   } grant_t;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*D_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ-1:0]         rsp_valid;
   logic [D_WIDTH-1:0]       rsp_data;
   logic [D_WIDTH-1:0]       sync_out;
   logic [D_WIDTH-1:0]       sync_in;
   logic                     busy;

   logic                     valid1;
   logic [D_WIDTH-1:0]       data1;
   logic                     ready1;
   logic                     rsp_valid1;
   logic [D_WIDTH-1:0]       rsp_data1;
   logic [D_WIDTH-1:0]       sync_out1;
   logic [D_WIDTH-1:0]       sync_in1;
   logic                     busy1;

   logic [D_WIDTH-1:0] pipe  [SYNC_STAGES];
   logic [D_WIDTH-1:0] pipe1 [SYNC_STAGES];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int last_accept = -1;

   rsp_t       rsp_q[$];
   grant_t     grant_q[$];
   int         accept_edge_q[$];
   logic [7:0] rsp1_q[$];
   logic [N_REQ-1:0] prev_rsp = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   data_sync_arb #(
      .D_WIDTH(D_WIDTH), .N_REQ(N_REQ),
      .SYNC_STAGES(SYNC_STAGES), .HOLD_EXTRA(HOLD_EXTRA)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_data_i(req_data),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
      .rsp_data_o(rsp_data), .sync_data_o(sync_out),
      .sync_data_i(sync_in), .busy_o(busy)
   );

   data_sync_arb #(
      .D_WIDTH(D_WIDTH), .N_REQ(1),
      .SYNC_STAGES(SYNC_STAGES), .HOLD_EXTRA(HOLD_EXTRA)
   ) dut1 (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(valid1), .req_data_i(data1),
      .req_ready_o(ready1), .rsp_valid_o(rsp_valid1),
      .rsp_data_o(rsp_data1), .sync_data_o(sync_out1),
      .sync_data_i(sync_in1), .busy_o(busy1)
   );

   // Behavioural stand-in for the shared data_sync of each instance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            pipe[i]  <= '0;
            pipe1[i] <= '0;
         end
      end else begin
         pipe[0]  <= sync_out;
         pipe1[0] <= sync_out1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe1[i] <= pipe1[i-1];
         end
      end
   end

   assign sync_in  = pipe[SYNC_STAGES-1];
   assign sync_in1 = pipe1[SYNC_STAGES-1];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s", name);
   endtask

   task automatic expectTxn(input int req, input logic [7:0] data, input int gap);
      grant_t g;
      rsp_t   r;
      g.req  = req;
      g.gap  = gap;
      r.req  = req;
      r.data = data;
      grant_q.push_back(g);
      rsp_q.push_back(r);
   endtask

   // Waits (bounded) for a negedge where some valid request is being accepted.
   task automatic waitHandshake(output bit ok);
      int waited = 0;
      @(negedge clk);
      while ((req_ready & req_valid) == '0 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      ok = ((req_ready & req_valid) != '0);
      if (!ok) failNow("handshake_timeout");
   endtask

   // Holds the request mask and words until n_accepts handshakes complete.
   task automatic applyStimulus(input logic [N_REQ-1:0] mask,
                                input logic [31:0] words, input int n_accepts);
      bit ok;
      req_valid = mask;
      req_data  = words;
      for (int k = 0; k < n_accepts; k++) begin
         waitHandshake(ok);
         if (!ok) break;
         @(posedge clk);
         #1;
      end
      req_valid = '0;
   endtask

   task automatic waitDrain();
      int waited = 0;
      while ((rsp_q.size() != 0 || rsp1_q.size() != 0) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (rsp_q.size() != 0 || rsp1_q.size() != 0) failNow("response_timeout");
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Accept monitor: checks grant order and spacing of back-to-back accepts.
   always @(negedge clk) begin
      if (rst_n && (req_ready & req_valid) != '0) begin
         int     edge_no;
         grant_t g;
         edge_no = cycle + 1;
         if (grant_q.size() == 0) begin
            failNow("unexpected_accept");
         end else begin
            g = grant_q.pop_front();
            checkOutput("grant_onehot", 32'(req_ready), 32'(1) << g.req);
            if (g.gap > 0 && last_accept >= 0)
               checkOutput("accept_gap", 32'(edge_no - last_accept), 32'(g.gap));
         end
         last_accept = edge_no;
         accept_edge_q.push_back(edge_no);
      end
   end

   // Response monitor for the four-requester instance.
   always @(negedge clk) begin
      if (rst_n && rsp_valid != '0) begin
         rsp_t r;
         if (prev_rsp != '0) failNow("rsp_pulse_width");
         if (rsp_q.size() == 0) begin
            failNow("unexpected_rsp");
         end else begin
            r = rsp_q.pop_front();
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << r.req);
            checkOutput("rsp_data", 32'(rsp_data), 32'(r.data));
            checkOutput("sync_data_hold", 32'(sync_out), 32'(r.data));
            checkOutput("busy_fall", 32'(busy), 32'(0));
            if (accept_edge_q.size() == 0)
               failNow("rsp_without_accept");
            else
               checkOutput("rsp_latency", 32'(cycle - accept_edge_q.pop_front()),
                           32'(LAT + 2));
         end
      end
      prev_rsp = rsp_valid;
   end

   // Response monitor for the single-requester instance.
   always @(negedge clk) begin
      if (rst_n && rsp_valid1) begin
         if (rsp1_q.size() == 0) begin
            failNow("n1_unexpected_rsp");
         end else begin
            checkOutput("n1_rsp_data", 32'(rsp_data1), 32'(rsp1_q.pop_front()));
            checkOutput("n1_busy_fall", 32'(busy1), 32'(0));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit         ok;
      logic [7:0] w;
      logic [7:0] words1 [3];
      int         prev_edge;

      // Reset with random requests: every output must read zero.
      rst_n     = 1'b0;
      req_valid = N_REQ'($urandom);
      req_data  = $urandom;
      valid1    = 1'b1;
      data1     = 8'h99;
      repeat (3) begin
         @(negedge clk);
         checkOutput("reset_ready", 32'(req_ready), 32'(0));
         checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'(0));
         checkOutput("reset_rsp_data", 32'(rsp_data), 32'(0));
         checkOutput("reset_sync_data", 32'(sync_out), 32'(0));
         checkOutput("reset_busy", 32'(busy), 32'(0));
         checkOutput("reset_n1_ready", 32'(ready1), 32'(0));
         req_valid = N_REQ'($urandom);
      end
      req_valid = '0;
      valid1    = 1'b0;
      rst_n     = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'(0));
      checkOutput("idle_ready", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;

      // Fairness: all four requesting, grant order 0,1,2,3,0,1 every 6 cycles.
      $display("[TB] fairness");
      expectTxn(0, 8'h11, 0);
      expectTxn(1, 8'h22, LAT + 3);
      expectTxn(2, 8'h33, LAT + 3);
      expectTxn(3, 8'h44, LAT + 3);
      expectTxn(0, 8'h11, LAT + 3);
      expectTxn(1, 8'h22, LAT + 3);
      applyStimulus(4'b1111, 32'h4433_2211, 6);
      waitDrain();

      // Single request from requester 2 (pointer sits at 2 after fairness).
      $display("[TB] single request");
      expectTxn(2, 8'hA5, 0);
      applyStimulus(4'b0100, 32'h00A5_0000, 1);
      waitDrain();

      // Pointer wrap: after granting 2, requester 3 beats requester 1.
      $display("[TB] pointer wrap");
      expectTxn(3, 8'hD3, 0);
      expectTxn(1, 8'hB1, LAT + 3);
      applyStimulus(4'b1010, 32'hD300_B100, 2);
      waitDrain();

      // Reset two cycles into WAIT: no response, pointer back to 0.
      $display("[TB] reset mid-wait");
      begin
         grant_t g;
         g.req = 2;
         g.gap = 0;
         grant_q.push_back(g);
      end
      req_valid = 4'b0100;
      req_data  = 32'h003C_0000;
      waitHandshake(ok);
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_sync_data", 32'(sync_out), 32'(0));
      checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'(0));
      checkOutput("midreset_rsp_data", 32'(rsp_data), 32'(0));
      checkOutput("midreset_busy", 32'(busy), 32'(0));
      accept_edge_q.delete();
      last_accept = -1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expectTxn(1, 8'h5A, 0);
      expectTxn(3, 8'h6E, LAT + 3);
      applyStimulus(4'b1010, 32'h6E00_5A00, 2);
      waitDrain();

      // Data integrity: back-to-back words from requester 1.
      $display("[TB] data integrity");
      for (int k = 0; k < 67; k++) begin
         case (k)
            0:       w = 8'h00;
            1:       w = 8'hFF;
            2:       w = 8'h55;
            default: w = 8'($urandom_range(0, 255));
         endcase
         expectTxn(1, w, (k == 0) ? 0 : LAT + 3);
         applyStimulus(4'b0010, 32'(w) << 8, 1);
      end
      waitDrain();

      // Single-requester instance: consecutive grants all go to index 0.
      $display("[TB] single requester instance");
      words1[0] = 8'h81;
      words1[1] = 8'h7E;
      words1[2] = 8'hC3;
      prev_edge = -1;
      valid1    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         int waited = 0;
         data1 = words1[k];
         rsp1_q.push_back(words1[k]);
         @(negedge clk);
         while (!(ready1 && valid1) && waited < 60) begin
            @(negedge clk);
            waited++;
         end
         if (!(ready1 && valid1)) begin
            failNow("n1_handshake_timeout");
            break;
         end
         if (prev_edge >= 0)
            checkOutput("n1_accept_gap", 32'(cycle + 1 - prev_edge), 32'(LAT + 3));
         prev_edge = cycle + 1;
         @(posedge clk);
         #1;
      end
      valid1 = 1'b0;
      waitDrain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
